// File: rtl/square_root.sv
// ---------------------------------------------------------------------------
// square_root
//   Sequential integer square-root peripheral. A bus write (CS=1, WE=1 on a
//   rising CLK edge) loads an 18-bit radicand. The next nine edges each
//   resolve one root bit, MSB first, using the restoring digit-by-digit
//   remainder method. The final result is floor(sqrt(DI)).
//
// Ports
//   CLK   in   1   system clock, rising-edge active
//   RST   in   1   synchronous reset, active-high, highest priority
//   CS    in   1   chip select
//   WE    in   1   write enable (write = CS & WE)
//   DI    in  18   unsigned radicand, sampled on a write edge
//   DO    out 18   {9'b0, root}; shows the partial root while DONE=0
//   DONE  out  1   1 = idle / result valid, 0 = computing
// ---------------------------------------------------------------------------
module square_root (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [17:0] DI,
  output logic [17:0] DO,
  output logic        DONE
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // r_op shifts left two bits per iteration so its top pair is always the
  // next radicand digit to bring down into the remainder.
  logic [17:0] r_op;
  logic [8:0]  r_root;
  logic [18:0] r_rem;
  logic [3:0]  r_cnt;

  logic        w_write;
  logic [18:0] w_rem_sh;
  logic [18:0] w_trial;
  logic [18:0] w_rem_sub;
  logic        w_keep;

  assign w_write   = CS & WE;

  // Bring down the next digit pair, then try subtracting (4*root + 1).
  // Keeping the subtraction is equivalent to setting the current root bit.
  assign w_rem_sh  = (r_rem << 2) | {17'b0, r_op[17:16]};
  assign w_trial   = {8'b0, r_root, 2'b01};
  assign w_keep    = (w_rem_sh >= w_trial);
  assign w_rem_sub = w_rem_sh - w_trial;

  assign DO   = {9'b0, r_root};
  assign DONE = (r_state == S_IDLE);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A write always (re)starts; the edge that consumes the
  // last counter value resolves bit 0 and returns to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_write) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_write) begin
          w_state_next = S_BUSY;
        end else if (r_cnt == 4'd1) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op   <= 18'd0;
      r_root <= 9'd0;
      r_rem  <= 19'd0;
      r_cnt  <= 4'd0;
    end else if (w_write) begin
      r_op   <= DI;
      r_root <= 9'd0;
      r_rem  <= 19'd0;
      r_cnt  <= 4'd9;
    end else if (r_state == S_BUSY) begin
      r_op  <= {r_op[15:0], 2'b00};
      r_cnt <= r_cnt - 4'd1;
      if (w_keep) begin
        r_rem  <= w_rem_sub;
        r_root <= {r_root[7:0], 1'b1};
      end else begin
        r_rem  <= w_rem_sh;
        r_root <= {r_root[7:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_square_root.sv
// ---------------------------------------------------------------------------
// tb_square_root
//   Directed bench for square_root. Inputs change on the falling edge,
//   outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_square_root;

  logic        CLK;
  logic        RST;
  logic        CS;
  logic        WE;
  logic [17:0] DI;
  logic [17:0] DO;
  logic        DONE;

  int n_tests;
  int n_failed;

  square_root dut (
    .CLK  (CLK),
    .RST  (RST),
    .CS   (CS),
    .WE   (WE),
    .DI   (DI),
    .DO   (DO),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One write edge; returns just after it with the bus idle again.
  task automatic do_write(input logic [17:0] v);
    @(negedge CLK);
    CS = 1'b1;
    WE = 1'b1;
    DI = v;
    tick();
    @(negedge CLK);
    CS = 1'b0;
    WE = 1'b0;
  endtask

  // Write v, then verify DONE timing and the final root.
  task automatic run_sqrt(input logic [17:0] v, input logic [17:0] exp_root);
    do_write(v);
    check($sformatf("busy_after_write(%0d)", v), {17'b0, DONE}, 18'd0);
    for (int i = 1; i <= 8; i++) tick();
    check($sformatf("busy_after_edge8(%0d)", v), {17'b0, DONE}, 18'd0);
    tick();
    check($sformatf("done_after_edge9(%0d)", v), {17'b0, DONE}, 18'd1);
    check($sformatf("root(%0d)", v), DO, exp_root);
    $display("[TB] sqrt(%0d) -> DO=%0d DONE=%0b (expected %0d)", v, DO, DONE, exp_root);
  endtask

  logic [17:0] vec_in  [0:13];
  logic [17:0] vec_exp [0:13];

  initial begin
    n_tests  = 0;
    n_failed = 0;
    RST = 1'b1;
    CS  = 1'b0;
    WE  = 1'b0;
    DI  = 18'd0;

    vec_in[0]  = 18'd0;      vec_exp[0]  = 18'd0;
    vec_in[1]  = 18'd16;     vec_exp[1]  = 18'd4;
    vec_in[2]  = 18'd1000;   vec_exp[2]  = 18'd31;
    vec_in[3]  = 18'd2500;   vec_exp[3]  = 18'd50;
    vec_in[4]  = 18'd10000;  vec_exp[4]  = 18'd100;
    vec_in[5]  = 18'd25000;  vec_exp[5]  = 18'd158;
    vec_in[6]  = 18'd100000; vec_exp[6]  = 18'd316;
    vec_in[7]  = 18'd262143; vec_exp[7]  = 18'd511;
    vec_in[8]  = 18'd1;      vec_exp[8]  = 18'd1;
    vec_in[9]  = 18'd3;      vec_exp[9]  = 18'd1;
    vec_in[10] = 18'd4;      vec_exp[10] = 18'd2;
    vec_in[11] = 18'd255;    vec_exp[11] = 18'd15;
    vec_in[12] = 18'd256;    vec_exp[12] = 18'd16;
    vec_in[13] = 18'd250000; vec_exp[13] = 18'd500;

    // Reset
    tick();
    tick();
    @(negedge CLK);
    RST = 1'b0;
    tick();
    check("reset_done", {17'b0, DONE}, 18'd1);
    check("reset_do", DO, 18'd0);
    for (int i = 0; i < 5; i++) tick();
    check("idle_done", {17'b0, DONE}, 18'd1);
    check("idle_do", DO, 18'd0);
    $display("[TB] reset: DO=%0d DONE=%0b", DO, DONE);

    // Directed values and boundaries; last one leaves DO=500
    for (int i = 0; i < 14; i++) run_sqrt(vec_in[i], vec_exp[i]);

    // No spurious start
    @(negedge CLK);
    CS = 1'b1; WE = 1'b0; DI = 18'd16;
    tick(); tick();
    check("cs_only_done", {17'b0, DONE}, 18'd1);
    check("cs_only_do", DO, 18'd500);
    @(negedge CLK);
    CS = 1'b0; WE = 1'b1;
    tick(); tick();
    check("we_only_done", {17'b0, DONE}, 18'd1);
    check("we_only_do", DO, 18'd500);
    @(negedge CLK);
    WE = 1'b0;
    $display("[TB] no-start: DO=%0d DONE=%0b", DO, DONE);

    // Restart mid-operation
    do_write(18'd250000);
    for (int i = 0; i < 3; i++) tick();
    check("restart_busy_before", {17'b0, DONE}, 18'd0);
    run_sqrt(18'd16, 18'd4);

    // Reset mid-operation
    do_write(18'd100000);
    for (int i = 0; i < 2; i++) tick();
    @(negedge CLK);
    RST = 1'b1;
    tick();
    @(negedge CLK);
    RST = 1'b0;
    check("midreset_done", {17'b0, DONE}, 18'd1);
    check("midreset_do", DO, 18'd0);
    $display("[TB] mid-op reset: DO=%0d DONE=%0b", DO, DONE);
    run_sqrt(18'd2500, 18'd50);

    // Write and reset on the same edge: reset wins
    @(negedge CLK);
    RST = 1'b1; CS = 1'b1; WE = 1'b1; DI = 18'd1000;
    tick();
    @(negedge CLK);
    RST = 1'b0; CS = 1'b0; WE = 1'b0;
    check("wr_rst_done", {17'b0, DONE}, 18'd1);
    check("wr_rst_do", DO, 18'd0);
    for (int i = 0; i < 10; i++) tick();
    check("wr_rst_stays_done", {17'b0, DONE}, 18'd1);
    check("wr_rst_stays_do", DO, 18'd0);
    $display("[TB] write+reset: DO=%0d DONE=%0b", DO, DONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
